star_random_position: RTL and testbench

//  Upstream of the star mover: supplies randomX/randomY, which the mover samples on every startOfFrame.
//  A free-running 16-bit LFSR drives rejection sampling into a legal play window, with a clamp fallback.

---
 rtl/star_pkg.sv | 40 ++++
 rtl/lfsr16.sv | 45 ++++
 rtl/star_random_position.sv | 168 ++++++++++++++++
 tb/tb_star_random_position.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/star_pkg.sv
// Shared widths, LFSR taps, relocation FSM state type and coordinate helpers
// for the star relocation logic.
package star_pkg;

  localparam int COORD_W = 11;
  localparam int LFSR_W  = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    GEN_X,
    GEN_Y,
    COMMIT
  } star_rnd_state_t;

  function automatic logic coord_in_range(
    input logic [COORD_W-1:0] cand,
    input logic [COORD_W-1:0] lo,
    input logic [COORD_W-1:0] hi
  );
    return (cand >= lo) && (cand <= hi);
  endfunction

  // Fallback when the draw budget is exhausted: pull the last candidate onto the window.
  function automatic logic [COORD_W-1:0] clamp_coord(
    input logic [COORD_W-1:0] cand,
    input logic [COORD_W-1:0] lo,
    input logic [COORD_W-1:0] hi
  );
    logic [COORD_W-1:0] res;
    res = cand;
    if (cand < lo) begin
      res = lo;
    end else if (cand > hi) begin
      res = hi;
    end
    return res;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift, taps from star_pkg), stepping
// every clock; a stuck all-zero state is recovered by reloading the seed.
module lfsr16
  import star_pkg::*;
(
  input  logic              clk,
  input  logic              resetN,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] out
);

  logic [LFSR_W-1:0] lfsr_reg;
  logic [LFSR_W-1:0] lfsr_next;
  logic [LFSR_W-1:0] shifted;

  // Each bit takes its upper neighbour, xored with the feedback bit where a tap sits.
  genvar gi;
  generate
    for (gi = 0; gi < LFSR_W; gi++) begin : g_tap
      if (gi == LFSR_W - 1) begin : g_msb
        assign shifted[gi] = LFSR_TAPS[gi] & lfsr_reg[0];
      end else begin : g_bit
        assign shifted[gi] = lfsr_reg[gi+1] ^ (LFSR_TAPS[gi] & lfsr_reg[0]);
      end
    end
  endgenerate

  always_comb begin
    lfsr_next = shifted;
    if (lfsr_reg == '0) begin
      lfsr_next = seed;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lfsr_reg <= seed;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign out = lfsr_reg;

endmodule

// File: rtl/star_random_position.sv
// Supplies randomX/randomY to the star mover: timed (and optionally hit-driven)
// relocation by rejection sampling with clamp fallback. Option: STAR_RELOC_ON_HIT_EN.
module star_random_position
  import star_pkg::*;
#(
  parameter int                INIT_X      = 392,
  parameter int                INIT_Y      = 228,
  parameter int                X_MIN       = 32,
  parameter int                X_MAX       = 543,
  parameter int                Y_MIN       = 32,
  parameter int                Y_MAX       = 415,
  parameter int                HOLD_FRAMES = 120,
  parameter int                MAX_TRIES   = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               starHit,
  output logic [COORD_W-1:0] randomX,
  output logic [COORD_W-1:0] randomY,
  output logic               newPosition
);

  localparam int FRAME_W = $clog2(HOLD_FRAMES + 1);
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);

  localparam logic [COORD_W-1:0] X_INIT_C = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] Y_INIT_C = COORD_W'(INIT_Y);
  localparam logic [COORD_W-1:0] X_LO     = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_HI     = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LO     = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] Y_HI     = COORD_W'(Y_MAX);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(HOLD_FRAMES - 1);
  localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES - 1);

  star_rnd_state_t    state_reg, state_next;
  logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic [TRIES_W-1:0] tries_reg, tries_next;
  logic [COORD_W-1:0] lat_x_reg, lat_x_next;
  logic [COORD_W-1:0] lat_y_reg, lat_y_next;
  logic [COORD_W-1:0] pos_x_reg, pos_x_next;
  logic [COORD_W-1:0] pos_y_reg, pos_y_next;
  logic               new_pos_reg, new_pos_next;

  logic [LFSR_W-1:0]  lfsr;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               timer_req;
  logic               hit_req;
  logic               req;

  lfsr16 u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .seed   (LFSR_SEED),
    .out    (lfsr)
  );

  // X and Y draw from overlapping LFSR slices; they are taken on different cycles.
  assign cand_x = {1'b0, lfsr[9:0]};
  assign cand_y = {2'b0, lfsr[15:7]};

  assign timer_req = startOfFrame & enable & (frame_cnt_reg == FRAME_LAST);

`ifdef STAR_RELOC_ON_HIT_EN
  assign hit_req = starHit & enable;
`else
  logic unused_star_hit;
  assign unused_star_hit = starHit;
  assign hit_req         = 1'b0;
`endif

  assign req = timer_req | hit_req;

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    tries_next     = tries_reg;
    lat_x_next     = lat_x_reg;
    lat_y_next     = lat_y_reg;
    pos_x_next     = pos_x_reg;
    pos_y_next     = pos_y_reg;
    new_pos_next   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (startOfFrame && enable) begin
          frame_cnt_next = frame_cnt_reg + FRAME_W'(1);
        end
        if (req) begin
          tries_next = '0;
          state_next = GEN_X;
        end
      end

      GEN_X: begin
        if (coord_in_range(cand_x, X_LO, X_HI)) begin
          lat_x_next = cand_x;
          tries_next = '0;
          state_next = GEN_Y;
        end else if (tries_reg == TRIES_LAST) begin
          lat_x_next = clamp_coord(cand_x, X_LO, X_HI);
          tries_next = '0;
          state_next = GEN_Y;
        end else begin
          tries_next = tries_reg + TRIES_W'(1);
        end
      end

      GEN_Y: begin
        if (coord_in_range(cand_y, Y_LO, Y_HI)) begin
          lat_y_next = cand_y;
          tries_next = '0;
          state_next = COMMIT;
        end else if (tries_reg == TRIES_LAST) begin
          lat_y_next = clamp_coord(cand_y, Y_LO, Y_HI);
          tries_next = '0;
          state_next = COMMIT;
        end else begin
          tries_next = tries_reg + TRIES_W'(1);
        end
      end

      // Both coordinates and the strobe update on the same edge, so the mover never
      // samples a half-updated pair.
      COMMIT: begin
        pos_x_next     = lat_x_reg;
        pos_y_next     = lat_y_reg;
        new_pos_next   = 1'b1;
        frame_cnt_next = '0;
        state_next     = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg     <= IDLE;
      frame_cnt_reg <= '0;
      tries_reg     <= '0;
      lat_x_reg     <= X_INIT_C;
      lat_y_reg     <= Y_INIT_C;
      pos_x_reg     <= X_INIT_C;
      pos_y_reg     <= Y_INIT_C;
      new_pos_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      tries_reg     <= tries_next;
      lat_x_reg     <= lat_x_next;
      lat_y_reg     <= lat_y_next;
      pos_x_reg     <= pos_x_next;
      pos_y_reg     <= pos_y_next;
      new_pos_reg   <= new_pos_next;
    end
  end

  assign randomX     = pos_x_reg;
  assign randomY     = pos_y_reg;
  assign newPosition = new_pos_reg;

endmodule

// File: tb/tb_star_random_position.sv
// Randomized bench for star_random_position: two instances (normal window and a narrow
// clamp-forcing X window) checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_star_random_position;

  localparam int HOLD = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int XLO   [2] = '{32, 1000};
  localparam int XHI   [2] = '{543, 1003};
  localparam int YLO   [2] = '{32, 32};
  localparam int YHI   [2] = '{415, 415};
  localparam int TRIES [2] = '{8, 2};
`ifdef STAR_RELOC_ON_HIT_EN
  localparam int HIT_PULSES = 1;
`else
  localparam int HIT_PULSES = 0;
`endif

  logic clk = 1'b0;
  logic resetN, sof, en, hit;
  logic [10:0] rx0, ry0, rx1, ry1;
  logic np0, np1;
  logic [10:0] rx [2];
  logic [10:0] ry [2];
  logic        np [2];

  always #5 clk = ~clk;

  star_random_position #(
    .INIT_X(392), .INIT_Y(228), .X_MIN(32), .X_MAX(543), .Y_MIN(32), .Y_MAX(415),
    .HOLD_FRAMES(HOLD), .MAX_TRIES(8), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en), .starHit(hit),
    .randomX(rx0), .randomY(ry0), .newPosition(np0)
  );

  star_random_position #(
    .INIT_X(392), .INIT_Y(228), .X_MIN(1000), .X_MAX(1003), .Y_MIN(32), .Y_MAX(415),
    .HOLD_FRAMES(HOLD), .MAX_TRIES(2), .LFSR_SEED(SEED)
  ) dut_clamp (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en), .starHit(hit),
    .randomX(rx1), .randomY(ry1), .newPosition(np1)
  );

  assign rx[0] = rx0;
  assign ry[0] = ry0;
  assign np[0] = np0;
  assign rx[1] = rx1;
  assign ry[1] = ry1;
  assign np[1] = np1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected within %0d..%0d", name, act, lo, hi);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'h0000) return SEED;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // One axis of a relocation: walk the LFSR sequence until a draw lands in [lo,hi]
  // or the budget runs out (then clamp the last draw).
  function automatic void draw(input int lo, input int hi, input int tries,
                               input logic [15:0] start, input bit is_y,
                               output int val, output int cyc, output logic [15:0] after);
    logic [15:0] v;
    int cand;
    v = start;
    val = 0;
    cyc = 0;
    after = start;
    for (int k = 1; k <= tries; k++) begin
      cand = is_y ? int'(v[15:7]) : int'(v[9:0]);
      if (cand >= lo && cand <= hi) begin
        val = cand; cyc = k; after = lfsr_next(v);
        return;
      end
      if (k == tries) begin
        val = (cand < lo) ? lo : hi;
        cyc = k; after = lfsr_next(v);
        return;
      end
      v = lfsr_next(v);
    end
  endfunction

  logic [15:0] m_lfsr [2];
  int  m_frame [2];
  int  m_cnt   [2];
  int  m_xc    [2];
  int  m_px    [2];
  int  m_py    [2];
  bit  m_busy  [2];
  int  exp_x   [2];
  int  exp_y   [2];
  bit  exp_np  [2];
  int  cyc = 0;

  task automatic model_edge(input int i);
    logic [15:0] after;
    int xc, yc, vx, vy;
    bit treq, hreq;
    exp_np[i] = 1'b0;
    if (m_busy[i]) begin
      m_cnt[i]--;
      if (m_cnt[i] == 0) begin
        exp_x[i] = m_px[i];
        exp_y[i] = m_py[i];
        exp_np[i] = 1'b1;
        m_busy[i] = 1'b0;
        m_frame[i] = 0;
      end
    end else begin
      treq = sof && en && (m_frame[i] == HOLD - 1);
      hreq = 1'b0;
`ifdef STAR_RELOC_ON_HIT_EN
      hreq = hit && en;
`endif
      if (sof && en) m_frame[i]++;
      if (treq || hreq) begin
        draw(XLO[i], XHI[i], TRIES[i], lfsr_next(m_lfsr[i]), 1'b0, vx, xc, after);
        draw(YLO[i], YHI[i], TRIES[i], after, 1'b1, vy, yc, after);
        m_px[i] = vx;
        m_py[i] = vy;
        m_xc[i] = xc;
        m_cnt[i] = xc + yc + 1;
        m_busy[i] = 1'b1;
      end
    end
    m_lfsr[i] = lfsr_next(m_lfsr[i]);
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 2; i++) begin
        m_lfsr[i] = SEED; m_frame[i] = 0; m_cnt[i] = 0; m_xc[i] = 0;
        m_px[i] = 392; m_py[i] = 228; m_busy[i] = 1'b0;
        exp_x[i] = 392; exp_y[i] = 228; exp_np[i] = 1'b0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) model_edge(i);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_on = 1'b0;
  int np_cnt [2] = '{0, 0};
  logic [10:0] prev_x [2];
  logic [10:0] prev_y [2];

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cyc%0d_dut%0d_randomX", cyc, i), int'(rx[i]), exp_x[i]);
        check($sformatf("cyc%0d_dut%0d_randomY", cyc, i), int'(ry[i]), exp_y[i]);
        check($sformatf("cyc%0d_dut%0d_newPosition", cyc, i), int'(np[i]), int'(exp_np[i]));
        if (resetN) begin
          check($sformatf("cyc%0d_dut%0d_change_without_pulse", cyc, i),
                int'(((rx[i] != prev_x[i]) || (ry[i] != prev_y[i])) && !np[i]), 0);
        end
        if (np[i]) np_cnt[i]++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      prev_x[i] = rx[i];
      prev_y[i] = ry[i];
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_sof();
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int base, found, got;
  int pv, pc;
  logic [15:0] pa;

  initial begin
    sof = 1'b0; en = 1'b0; hit = 1'b0; resetN = 1'b0;

    // Hand-derived pins for the model itself.
    check("pin_lfsr_step1", int'(lfsr_next(16'hACE1)), 'hE270);
    check("pin_lfsr_step2", int'(lfsr_next(16'hE270)), 'h7138);
    draw(32, 543, 8, 16'hE270, 1'b0, pv, pc, pa);
    check("pin_draw_x_value", pv, 312);
    check("pin_draw_x_cycles", pc, 2);
    draw(1000, 1003, 2, 16'hE270, 1'b0, pv, pc, pa);
    check("pin_clamp_x_value", pv, 1000);
    check("pin_clamp_x_cycles", pc, 2);

    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    check("reset_randomX", int'(rx0), 392);
    check("reset_randomY", int'(ry0), 228);
    check("reset_newPosition", int'(np0), 0);
    #1 resetN = 1'b1;
    @(negedge clk);

    // 1: frames with enable low never relocate.
    #1 base = np_cnt[0];
    repeat (5) begin pulse_sof(); idle(3); end
    #1;
    check("t1_no_pulse_disabled", np_cnt[0] - base, 0);
    check("t1_randomX_hold", int'(rx0), 392);
    check("t1_randomY_hold", int'(ry0), 228);

    // 2: timer relocation after HOLD frames, bounded latency.
    en = 1'b1;
    repeat (HOLD - 1) begin pulse_sof(); idle(3); end
    pulse_sof();
    found = 0;
    for (int k = 0; k <= 17; k++) begin
      if (np0) begin found = 1; break; end
      if (k < 17) @(negedge clk);
    end
    check("t2_pulse_within_17", found, 1);
    check_range("t2_randomX_window", int'(rx0), 32, 543);
    check_range("t2_randomY_window", int'(ry0), 32, 415);
    check_range("t5_clamped_randomX", int'(rx1), 1000, 1003);
    idle(20);
    #1 base = np_cnt[0];
    repeat (HOLD - 1) begin pulse_sof(); idle(3); end
    #1;
    check("t2_frame_count_restarted", np_cnt[0] - base, 0);

    // 3/4: star hits in IDLE, second hit while generating.
    idle(2);
    #1 base = np_cnt[0];
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    idle(25);
    #1;
    check("t3_hit_pulses", np_cnt[0] - base, HIT_PULSES);

    // 6: reset while the clamp instance is in GEN_Y.
    got = 0;
    for (int k = 0; k < 8; k++) begin
      pulse_sof();
      if (m_busy[1]) begin got = 1; break; end
      idle(2);
    end
    check("t6_request_started", got, 1);
    if (got == 1) begin
      repeat (m_xc[1]) @(negedge clk);
      #1 resetN = 1'b0;
      #1;
      check("t6_reset_randomX", int'(rx0), 392);
      check("t6_reset_randomY", int'(ry0), 228);
      check("t6_reset_clamp_randomX", int'(rx1), 392);
      check("t6_reset_clamp_randomY", int'(ry1), 228);
      check("t6_reset_newPosition", int'(np0 | np1), 0);
      idle(3);
      #1 resetN = 1'b1;
      base = np_cnt[0] + np_cnt[1];
      idle(20);
      #1;
      check("t6_no_pulse_after_reset", np_cnt[0] + np_cnt[1] - base, 0);
    end

    // Randomized traffic, checked cycle by cycle against the model.
    repeat (4000) begin
      @(negedge clk);
      sof = ($urandom_range(0, 5) == 0);
      en  = ($urandom_range(0, 9) != 0);
      hit = ($urandom_range(0, 24) == 0);
    end
    @(negedge clk);
    sof = 1'b0; hit = 1'b0;
    idle(20);
    #1;
    check_range("rand_relocations_seen", np_cnt[0], 2, 100000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
